// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
//   Shared definitions for the instruction-fetch stage: fetch FSM states,
//   PC increment, flush value for the instruction slot and a PC alignment
//   helper.
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE,   // no request; waiting for halt to drop
    FETCH,  // request to imem may be in flight
    FULL,   // skid buffer occupied, fetching paused
    DRAIN   // redirected while a request was outstanding; discard its data
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  // Redirect targets are word addresses; the low two bits are ignored.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid.sv
// ---------------------------------------------------------------------------
// if_skid_buf
//   One-entry holding buffer for a fetched {ins, pc, pcand4} triple, used
//   when a word returns from memory while the IF/ID slot is stalled.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_load                 capture i_ins/i_pc/i_pcand4, mark valid
//   i_pop                  entry consumed, mark empty
//   i_clear                flush (redirect), mark empty
//   o_valid                entry holds a word
//   o_ins/o_pc/o_pcand4    stored triple
// ---------------------------------------------------------------------------
module if_skid_buf
  import if_fetch_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_pop,
  input  logic        i_clear,
  input  logic [31:0] i_ins,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pcand4,
  output logic        o_valid,
  output logic [31:0] o_ins,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcand4
);

  logic        r_valid;
  logic [31:0] r_ins;
  logic [31:0] r_pc;
  logic [31:0] r_pcand4;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid  <= 1'b0;
      r_ins    <= NOP_INS;
      r_pc     <= '0;
      r_pcand4 <= '0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_ins    <= i_ins;
      r_pc     <= i_pc;
      r_pcand4 <= i_pcand4;
    end else if (i_pop) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_ins    = r_ins;
  assign o_pc     = r_pc;
  assign o_pcand4 = r_pcand4;

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage feeding the IF/ID register. Owns the fetch PC,
//   requests words from instruction memory over a req/ack handshake and
//   presents {ins, pc, pc+4, status} to IF/ID. Honours stall, redirect and
//   halt; a one-entry skid buffer keeps a word that returns during a stall.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    IF/ID hold
//   halt                     start no new fetch
//   redirect, redirect_pc    flush and refetch from redirect_pc (word aligned)
//   imem_req, imem_addr      fetch request / address (held until ack)
//   imem_ack, imem_rdata     1-cycle response strobe / instruction word
//   ins_out, pc_out,
//   pcand4_out, status_out   IF/ID payload and valid flag
// ---------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_out,
  output logic [31:0] pcand4_out,
  output logic [31:0] pc_out,
  output logic        status_out
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  w_fetch_pc_nxt;
  logic [31:0]  r_req_pc;
  logic         r_busy;       // request issued earlier and still unacked

  logic [31:0]  r_ins;
  logic [31:0]  r_pc;
  logic [31:0]  r_pcand4;
  logic         r_status;

  logic [31:0]  w_redirect_pc;
  logic         w_req;
  logic         w_ack;
  logic         w_slot_free;
  logic         w_take;
  logic         w_to_out;
  logic         w_to_skid;
  logic         w_pop;
  logic         w_hold_req;

  logic         w_skid_valid;
  logic [31:0]  w_skid_ins;
  logic [31:0]  w_skid_pc;
  logic [31:0]  w_skid_pcand4;

  assign w_redirect_pc = align_pc(redirect_pc);
  assign w_slot_free   = !r_status || !stall;

  // A fresh request in FETCH is suppressed by halt; once issued it is held
  // regardless of halt until acked.
  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      FETCH:   w_req = r_busy || !halt;
      DRAIN:   w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
    if (rst) begin
      w_req = 1'b0;
    end
  end

  assign w_ack      = imem_ack && w_req;
  assign w_take     = (r_state == FETCH) && w_ack && !redirect;
  assign w_to_out   = w_take && w_slot_free;
  assign w_to_skid  = w_take && !w_slot_free;
  assign w_pop      = (r_state == FULL) && w_skid_valid && !stall && !redirect;
  assign w_hold_req = (r_state == FETCH) && w_req && !w_ack && !redirect;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    if (redirect) begin
      w_fetch_pc_nxt = w_redirect_pc;
    end
    unique case (r_state)
      IDLE: begin
        if (!halt) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (w_ack) begin
          if (!redirect) begin
            w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
          end
          if (w_to_skid) begin
            w_state_nxt = FULL;
          end else begin
            w_state_nxt = halt ? IDLE : FETCH;
          end
        end else if (redirect) begin
          w_state_nxt = DRAIN;
        end
      end
      FULL: begin
        if (redirect || !stall) begin
          w_state_nxt = halt ? IDLE : FETCH;
        end
      end
      DRAIN: begin
        if (w_ack) begin
          w_state_nxt = halt ? IDLE : FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // req_pc is reloaded whenever the next FETCH cycle starts a new request,
  // so imem_addr stays put for an outstanding (or draining) request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_busy     <= w_hold_req;
      if ((w_state_nxt == FETCH) && !w_hold_req) begin
        r_req_pc <= w_fetch_pc_nxt;
      end
    end
  end

  // Redirect beats everything; a new word needs a free slot, else the skid
  // holds it until the stall releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ins    <= NOP_INS;
      r_pc     <= '0;
      r_pcand4 <= '0;
      r_status <= 1'b0;
    end else if (redirect) begin
      r_ins    <= NOP_INS;
      r_status <= 1'b0;
    end else if (w_to_out) begin
      r_ins    <= imem_rdata;
      r_pc     <= r_req_pc;
      r_pcand4 <= r_req_pc + PC_STEP;
      r_status <= 1'b1;
    end else if (w_pop) begin
      r_ins    <= w_skid_ins;
      r_pc     <= w_skid_pc;
      r_pcand4 <= w_skid_pcand4;
      r_status <= 1'b1;
    end else if (!stall) begin
      r_status <= 1'b0;
    end
  end

  if_skid_buf u_skid (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (w_to_skid),
    .i_pop    (w_pop),
    .i_clear  (redirect),
    .i_ins    (imem_rdata),
    .i_pc     (r_req_pc),
    .i_pcand4 (r_req_pc + PC_STEP),
    .o_valid  (w_skid_valid),
    .o_ins    (w_skid_ins),
    .o_pc     (w_skid_pc),
    .o_pcand4 (w_skid_pcand4)
  );

  assign imem_req   = w_req;
  assign imem_addr  = r_req_pc;
  assign ins_out    = r_ins;
  assign pc_out     = r_pc;
  assign pcand4_out = r_pcand4;
  assign status_out = r_status;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins_out;
  logic [31:0] pcand4_out;
  logic [31:0] pc_out;
  logic        status_out;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .halt       (halt),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ins_out    (ins_out),
    .pcand4_out (pcand4_out),
    .pc_out     (pc_out),
    .status_out (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory content is a fixed function of the address.
  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
  endfunction

  // Memory with a configurable number of wait states per request.
  int unsigned wait_min  = 0;
  int unsigned wait_max  = 0;
  int unsigned wait_left = 0;
  assign imem_ack   = imem_req && (wait_left == 0);
  assign imem_rdata = imem_ack ? ins_of(imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst || !(imem_req && !imem_ack))
      wait_left <= $urandom_range(wait_max, wait_min);
    else
      wait_left <= wait_left - 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    next_cyc();
    to_neg();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_status", {31'd0, status_out}, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_pcand4", pcand4_out, 32'd0);
    chk("rst_ins", ins_out, 32'd0);
    next_cyc();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        halt;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_status;
    logic [31:0] exp_pc;
    logic        exp_ins0;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  task automatic set_vec(input int i, input logic st, input logic hl, input logic rd,
                         input logic [31:0] rp, input logic er, input logic [31:0] ea,
                         input logic es, input logic [31:0] ep, input logic ez);
    vecs[i] = '{st, hl, rd, rp, er, ea, es, ep, ez};
  endtask

  logic [31:0] exp_pc;
  logic        flush_pend;
  logic        pend;
  logic [31:0] pend_addr;
  int          delivered;
  int          k;

  initial begin
    // Zero-wait memory: stream, stall with skid, redirect+ack+stall, halt.
    set_vec( 0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   1'b1);
    set_vec( 1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0,   1'b0);
    set_vec( 2, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4,   1'b0);
    set_vec( 3, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8,   1'b0);
    set_vec( 4, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   1'b0);
    set_vec( 5, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   1'b0);
    set_vec( 6, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8,   1'b0);
    set_vec( 7, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC,   1'b0);
    set_vec( 8, 1'b1, 1'b0, 1'b1, 32'h103, 1'b1, 32'h14,  1'b1, 32'h10,  1'b0);
    set_vec( 9, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h10,  1'b1);
    set_vec(10, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 1'b0);
    set_vec(11, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b0);
    set_vec(12, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b0);
    set_vec(13, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h100, 1'b0);
    set_vec(14, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104, 1'b0);

    wait_min = 0; wait_max = 0;
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      stall = vecs[i].stall; halt = vecs[i].halt;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      to_neg();
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_status", i), {31'd0, status_out}, {31'd0, vecs[i].exp_status});
      chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
      if (vecs[i].exp_status) begin
        chk($sformatf("vec%0d_ins", i), ins_out, ins_of(vecs[i].exp_pc));
        chk($sformatf("vec%0d_pcand4", i), pcand4_out, vecs[i].exp_pc + 32'd4);
      end
      if (vecs[i].exp_ins0)
        chk($sformatf("vec%0d_ins_zero", i), ins_out, 32'd0);
      next_cyc();
    end

    // 2-wait memory, redirect while the request is outstanding.
    wait_min = 2; wait_max = 2;
    do_reset();
    to_neg();
    chk("drain_c0_req", {31'd0, imem_req}, 32'd1);
    chk("drain_c0_ack", {31'd0, imem_ack}, 32'd0);
    next_cyc();
    redirect = 1'b1; redirect_pc = 32'h100;
    to_neg();
    chk("drain_c1_addr", imem_addr, 32'h0);
    chk("drain_c1_ack", {31'd0, imem_ack}, 32'd0);
    next_cyc();
    redirect = 1'b0;
    to_neg();
    chk("drain_c2_req", {31'd0, imem_req}, 32'd1);
    chk("drain_c2_addr", imem_addr, 32'h0);
    chk("drain_c2_ack", {31'd0, imem_ack}, 32'd1);
    chk("drain_c2_status", {31'd0, status_out}, 32'd0);
    next_cyc();
    to_neg();
    chk("drain_c3_addr", imem_addr, 32'h100);
    chk("drain_c3_status", {31'd0, status_out}, 32'd0);
    k = 0;
    while (!status_out && k < 10) begin
      next_cyc(); to_neg(); k++;
    end
    chk("drain_deliver_status", {31'd0, status_out}, 32'd1);
    chk("drain_deliver_pc", pc_out, 32'h100);
    chk("drain_deliver_ins", ins_out, ins_of(32'h100));
    next_cyc();

    // Halt with a request outstanding: it completes, then fetching pauses.
    do_reset();
    to_neg();
    chk("halt_c0_addr", imem_addr, 32'h0);
    next_cyc();
    halt = 1'b1;
    to_neg();
    chk("halt_c1_req_held", {31'd0, imem_req}, 32'd1);
    next_cyc();
    to_neg();
    chk("halt_c2_ack", {31'd0, imem_ack}, 32'd1);
    next_cyc();
    to_neg();
    chk("halt_c3_req", {31'd0, imem_req}, 32'd0);
    chk("halt_c3_status", {31'd0, status_out}, 32'd1);
    chk("halt_c3_pc", pc_out, 32'h0);
    next_cyc();
    halt = 1'b0;
    to_neg();
    chk("halt_c4_req", {31'd0, imem_req}, 32'd0);
    next_cyc();
    to_neg();
    chk("halt_c5_req", {31'd0, imem_req}, 32'd1);
    chk("halt_c5_addr", imem_addr, 32'h4);
    next_cyc();

    // PC wrap at the top of the address space, then reset mid-request.
    wait_min = 0; wait_max = 0;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    to_neg();
    next_cyc();
    redirect = 1'b0;
    to_neg();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_flush_status", {31'd0, status_out}, 32'd0);
    next_cyc();
    wait_min = 2; wait_max = 2;
    to_neg();
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_pcand4", pcand4_out, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    next_cyc();
    to_neg();
    chk("midrst_req_outstanding", {31'd0, imem_req && !imem_ack}, 32'd1);
    next_cyc();
    rst = 1'b1;
    to_neg();
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    next_cyc();
    rst = 1'b0;
    to_neg();
    chk("midrst_status", {31'd0, status_out}, 32'd0);
    chk("midrst_restart_req", {31'd0, imem_req}, 32'd1);
    chk("midrst_restart_addr", imem_addr, 32'h0);
    next_cyc();

    // Random traffic checked against an in-order delivery scoreboard.
    wait_min = 0; wait_max = 2;
    do_reset();
    exp_pc = 32'h0; flush_pend = 1'b0; pend = 1'b0; pend_addr = '0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      stall       = ($urandom_range(99, 0) < 30);
      halt        = ($urandom_range(99, 0) < 15);
      redirect    = ($urandom_range(99, 0) < 4);
      redirect_pc = $urandom();
      to_neg();
      if (flush_pend)
        chk("rand_flush_status", {31'd0, status_out}, 32'd0);
      if (pend) begin
        chk("rand_req_held", {31'd0, imem_req}, 32'd1);
        chk("rand_addr_stable", imem_addr, pend_addr);
      end
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
      if (redirect) begin
        exp_pc     = redirect_pc & ~32'h3;
        flush_pend = 1'b1;
      end else begin
        flush_pend = 1'b0;
        if (status_out && !stall) begin
          chk("rand_pc", pc_out, exp_pc);
          chk("rand_ins", ins_out, ins_of(exp_pc));
          chk("rand_pcand4", pcand4_out, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
      end
      next_cyc();
    end
    chk("rand_progress", {31'd0, delivered >= 200}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
